// File: rtl/lcd_pixel_writer_pkg.sv
// Shared types and constants for the LCD pixel writer: register select codes,
// DMG shade colours, frame-buffer geometry and the mixed-pixel record.
package lcd_pixel_writer_pkg;

  localparam int FB_WIDTH_PX = 160;
  localparam int FB_LINES_PX = 144;

  typedef enum logic [1:0] {
    SEL_BCPS = 2'd0,
    SEL_BCPD = 2'd1,
    SEL_OCPS = 2'd2,
    SEL_OCPD = 2'd3
  } reg_sel_e;

  typedef enum logic {
    SRC_BG  = 1'b0,
    SRC_OBJ = 1'b1
  } pix_src_e;

  localparam logic [14:0] SHADE_0 = 15'h7FFF;
  localparam logic [14:0] SHADE_1 = 15'h56B5;
  localparam logic [14:0] SHADE_2 = 15'h294A;
  localparam logic [14:0] SHADE_3 = 15'h0000;

  typedef struct packed {
    pix_src_e   src;
    logic [2:0] pal;
    logic [1:0] color;
    logic [7:0] x;
    logic [7:0] ly;
  } mix_pix_t;

  // Map a colour index through a DMG palette register to RGB555.
  function automatic logic [14:0] dmg_shade(input logic [7:0] pal_reg, input logic [1:0] c);
    logic [1:0] s;
    s = pal_reg[{c, 1'b0} +: 2];
    case (s)
      2'd0:    dmg_shade = SHADE_0;
      2'd1:    dmg_shade = SHADE_1;
      2'd2:    dmg_shade = SHADE_2;
      default: dmg_shade = SHADE_3;
    endcase
  endfunction

endpackage

// File: rtl/cgb_palette_ram.sv
// 64-byte CGB palette memory with its CPS index register, CPU data port and
// an independent registered pixel read port returning one RGB555 entry.
module cgb_palette_ram (
  input  logic        clk,
  input  logic        reset,
  input  logic        cps_wr,
  input  logic        cpd_wr,
  input  logic [7:0]  wdata,
  output logic [7:0]  cps_rdata,
  output logic [7:0]  cpd_rdata,
  input  logic        pix_rd_en,
  input  logic [2:0]  pix_pal,
  input  logic [1:0]  pix_color,
  output logic [14:0] pix_rdata
);

  logic [7:0] r_mem [64];
  logic [5:0] r_index;
  logic       r_inc;
  logic [7:0] r_pix_lo;
  logic [6:0] r_pix_hi;
  logic [5:0] w_pix_addr;

  assign w_pix_addr = {pix_pal, pix_color, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) r_mem[i] <= 8'hFF;
      r_index  <= '0;
      r_inc    <= 1'b0;
      r_pix_lo <= '0;
      r_pix_hi <= '0;
    end else begin
      if (cps_wr) begin
        r_index <= wdata[5:0];
        r_inc   <= wdata[7];
      end else if (cpd_wr) begin
        r_mem[r_index] <= wdata;
        if (r_inc) r_index <= r_index + 6'd1;
      end
      // Reads sample the array before this clk's CPU write lands.
      if (pix_rd_en) begin
        r_pix_lo <= r_mem[w_pix_addr];
        r_pix_hi <= r_mem[w_pix_addr | 6'd1][6:0];
      end
    end
  end

  assign cps_rdata = {r_inc, 1'b1, r_index};
  assign cpd_rdata = r_mem[r_index];
  assign pix_rdata = {r_pix_hi, r_pix_lo};

endmodule

// File: rtl/lcd_pixel_writer.sv
// Mixes BG and sprite dots, maps the winner to RGB555 via DMG registers or
// CGB palette RAM, and writes one frame-buffer word per visible dot.
module lcd_pixel_writer
  import lcd_pixel_writer_pkg::*;
#(
  parameter int FB_WIDTH = FB_WIDTH_PX,
  parameter int FB_LINES = FB_LINES_PX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk_en,
  input  logic        cgb,
  input  logic        rendering,
  input  logic [7:0]  pixel_x,
  input  logic [7:0]  ly,
  input  logic [5:0]  bg_pixel,
  input  logic        bg_master,
  input  logic [1:0]  sp_color,
  input  logic [2:0]  sp_palette,
  input  logic        sp_dmg_pal,
  input  logic        sp_behind_bg,
  input  logic [7:0]  bgp,
  input  logic [7:0]  obp0,
  input  logic [7:0]  obp1,
  input  logic        reg_wr,
  input  logic [1:0]  reg_sel,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [14:0] fb_wdata,
  output logic        frame_done
);

  reg_sel_e    w_sel;
  logic        w_accept;
  logic        w_sprite_wins;
  logic [1:0]  w_bc;
  mix_pix_t    w_mix;
  logic [14:0] w_fb_addr;
  logic        w_last;
  logic [7:0]  w_dmg_reg;
  logic [7:0]  w_bcps_rd, w_bcpd_rd, w_ocps_rd, w_ocpd_rd;
  logic [14:0] w_bg_rgb, w_obj_rgb;
  logic        w_lookup;

  logic        r_s0_valid;
  mix_pix_t    r_s0;
  logic        r_s1_valid;
  logic        r_s1_cgb;
  pix_src_e    r_s1_src;
  logic [14:0] r_s1_dmg_rgb;
  logic [14:0] r_s1_addr;
  logic        r_s1_last;

  assign w_sel    = reg_sel_e'(reg_sel);
  assign w_accept = slow_clk_en & rendering & (pixel_x < 8'(FB_WIDTH));
  assign w_bc     = bg_pixel[1:0];

  always_comb begin
    w_sprite_wins = 1'b0;
    if (sp_color == 2'd0)
      w_sprite_wins = 1'b0;
    else if (cgb)
      w_sprite_wins = !bg_master ? 1'b1 :
                      !((w_bc != 2'd0) && (bg_pixel[5] || sp_behind_bg));
    else
      w_sprite_wins = !(sp_behind_bg && (w_bc != 2'd0));
  end

  always_comb begin
    w_mix       = '0;
    w_mix.src   = w_sprite_wins ? SRC_OBJ : SRC_BG;
    w_mix.pal   = w_sprite_wins ? (cgb ? sp_palette : {2'b00, sp_dmg_pal}) : bg_pixel[4:2];
    w_mix.color = w_sprite_wins ? sp_color : w_bc;
    w_mix.x     = pixel_x;
    w_mix.ly    = ly;
  end

  // ly*160 + x as shifts; values past 15 bits are off-screen anyway.
  assign w_fb_addr = (15'(r_s0.ly) << 7) + (15'(r_s0.ly) << 5) + 15'(r_s0.x);
  assign w_last    = (r_s0.x == 8'(FB_WIDTH - 1)) && (r_s0.ly == 8'(FB_LINES - 1));
  assign w_dmg_reg = (r_s0.src == SRC_BG) ? bgp : (r_s0.pal[0] ? obp1 : obp0);
  assign w_lookup  = slow_clk_en & r_s0_valid & cgb;

  cgb_palette_ram u_bg_pal (
    .clk       (clk),
    .reset     (reset),
    .cps_wr    (reg_wr && (w_sel == SEL_BCPS)),
    .cpd_wr    (reg_wr && (w_sel == SEL_BCPD)),
    .wdata     (reg_wdata),
    .cps_rdata (w_bcps_rd),
    .cpd_rdata (w_bcpd_rd),
    .pix_rd_en (w_lookup && (r_s0.src == SRC_BG)),
    .pix_pal   (r_s0.pal),
    .pix_color (r_s0.color),
    .pix_rdata (w_bg_rgb)
  );

  cgb_palette_ram u_obj_pal (
    .clk       (clk),
    .reset     (reset),
    .cps_wr    (reg_wr && (w_sel == SEL_OCPS)),
    .cpd_wr    (reg_wr && (w_sel == SEL_OCPD)),
    .wdata     (reg_wdata),
    .cps_rdata (w_ocps_rd),
    .cpd_rdata (w_ocpd_rd),
    .pix_rd_en (w_lookup && (r_s0.src == SRC_OBJ)),
    .pix_pal   (r_s0.pal),
    .pix_color (r_s0.color),
    .pix_rdata (w_obj_rgb)
  );

  always_comb begin
    reg_rdata = 8'h00;
    case (w_sel)
      SEL_BCPS: reg_rdata = w_bcps_rd;
      SEL_BCPD: reg_rdata = w_bcpd_rd;
      SEL_OCPS: reg_rdata = w_ocps_rd;
      SEL_OCPD: reg_rdata = w_ocpd_rd;
      default:  reg_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_valid   <= 1'b0;
      r_s0         <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_cgb     <= 1'b0;
      r_s1_src     <= SRC_BG;
      r_s1_dmg_rgb <= '0;
      r_s1_addr    <= '0;
      r_s1_last    <= 1'b0;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_wdata     <= '0;
      frame_done   <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (slow_clk_en) begin
        r_s0_valid   <= w_accept;
        r_s0         <= w_mix;
        r_s1_valid   <= r_s0_valid;
        r_s1_cgb     <= cgb;
        r_s1_src     <= r_s0.src;
        r_s1_dmg_rgb <= dmg_shade(w_dmg_reg, r_s0.color);
        r_s1_addr    <= w_fb_addr;
        r_s1_last    <= w_last;
        if (r_s1_valid) begin
          fb_we      <= 1'b1;
          fb_addr    <= r_s1_addr;
          fb_wdata   <= r_s1_cgb ? ((r_s1_src == SRC_OBJ) ? w_obj_rgb : w_bg_rgb) : r_s1_dmg_rgb;
          frame_done <= r_s1_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_pixel_writer.sv
// Directed bench for lcd_pixel_writer: palette registers, priority, DMG/CGB
// colour mapping, latency, frame_done, off-screen dots and mid-pipeline reset.
module tb_lcd_pixel_writer;

  logic        clk = 1'b0;
  logic        reset, slow_clk_en, cgb, rendering;
  logic [7:0]  pixel_x, ly;
  logic [5:0]  bg_pixel;
  logic        bg_master;
  logic [1:0]  sp_color;
  logic [2:0]  sp_palette;
  logic        sp_dmg_pal, sp_behind_bg;
  logic [7:0]  bgp, obp0, obp1;
  logic        reg_wr;
  logic [1:0]  reg_sel;
  logic [7:0]  reg_wdata, reg_rdata;
  logic        fb_we, frame_done;
  logic [14:0] fb_addr, fb_wdata;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lcd_pixel_writer dut (
    .clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cgb(cgb),
    .rendering(rendering), .pixel_x(pixel_x), .ly(ly), .bg_pixel(bg_pixel),
    .bg_master(bg_master), .sp_color(sp_color), .sp_palette(sp_palette),
    .sp_dmg_pal(sp_dmg_pal), .sp_behind_bg(sp_behind_bg),
    .bgp(bgp), .obp0(obp0), .obp1(obp1),
    .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    reg_wr = 1'b1; reg_sel = sel; reg_wdata = d;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic reg_check(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    reg_sel = sel;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  // One dot accepted, then two more enables with rendering low; the write
  // must appear only after the second of those enables, for one clk.
  task automatic dot(input string tag, input logic rend, input logic [7:0] x, input logic [7:0] y,
                     input logic exp_we, input logic [14:0] ea, input logic [14:0] ed,
                     input logic efd);
    @(negedge clk); slow_clk_en = 1'b1; rendering = rend; pixel_x = x; ly = y;
    @(negedge clk); slow_clk_en = 1'b0; rendering = 1'b0;
    @(negedge clk); slow_clk_en = 1'b1;
    @(negedge clk); slow_clk_en = 1'b0;
    check({tag, ".early_we"}, fb_we, 0);
    @(negedge clk); slow_clk_en = 1'b1;
    @(negedge clk); slow_clk_en = 1'b0;
    check({tag, ".we"}, fb_we, exp_we);
    if (exp_we) begin
      check({tag, ".addr"}, fb_addr, ea);
      check({tag, ".data"}, fb_wdata, ed);
    end
    check({tag, ".frame_done"}, frame_done, efd);
    @(negedge clk);
    check({tag, ".we_end"}, fb_we, 0);
  endtask

  initial begin
    reset = 1'b1; slow_clk_en = 1'b0; cgb = 1'b0; rendering = 1'b0;
    pixel_x = '0; ly = '0; bg_pixel = '0; bg_master = 1'b1;
    sp_color = '0; sp_palette = '0; sp_dmg_pal = 1'b0; sp_behind_bg = 1'b0;
    bgp = 8'hE4; obp0 = 8'hE4; obp1 = 8'h1B;
    reg_wr = 1'b0; reg_sel = '0; reg_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst.fb_we", fb_we, 0);
    check("rst.frame_done", frame_done, 0);
    check("rst.fb_addr", fb_addr, 0);
    check("rst.fb_wdata", fb_wdata, 0);
    reg_check("rst.bcps", 2'd0, 8'h40);
    reg_check("rst.ocps", 2'd2, 8'h40);
    reg_check("rst.bcpd", 2'd1, 8'hFF);

    // DMG background colour 2 through BGP 0xE4
    bg_pixel = 6'b000010; sp_color = 2'd0;
    dot("dmg_bg", 1'b1, 8'd5, 8'd0, 1'b1, 15'd5, 15'h294A, 1'b0);

    // CGB palette 1 colour 0 = red, at the last dot of the frame
    cgb = 1'b1;
    reg_write(2'd0, 8'h88);
    reg_write(2'd1, 8'h1F);
    reg_write(2'd1, 8'h00);
    reg_check("cgb.bcps_inc", 2'd0, 8'hCA);
    reg_check("cgb.bcpd_rd", 2'd1, 8'hFF);
    reg_check("cgb.bcps_noinc", 2'd0, 8'hCA);
    bg_pixel = 6'b000100;
    dot("cgb_last", 1'b1, 8'd159, 8'd143, 1'b1, 15'd23039, 15'h001F, 1'b1);

    // BG pal1 col1 = 0x1234, OBJ pal2 col3 = 0x5678
    reg_write(2'd0, 8'h8A);
    reg_write(2'd1, 8'h34);
    reg_write(2'd1, 8'h12);
    reg_write(2'd2, 8'h96);
    reg_write(2'd3, 8'h78);
    reg_write(2'd3, 8'h56);
    bg_pixel = 6'b100101; sp_color = 2'd3; sp_palette = 3'd2; sp_behind_bg = 1'b0;
    bg_master = 1'b1;
    dot("cgb_prio_bg", 1'b1, 8'd10, 8'd3, 1'b1, 15'd490, 15'h1234, 1'b0);
    bg_master = 1'b0;
    dot("cgb_master0", 1'b1, 8'd10, 8'd3, 1'b1, 15'd490, 15'h5678, 1'b0);
    bg_master = 1'b1; bg_pixel = 6'b000101;
    dot("cgb_noprio", 1'b1, 8'd10, 8'd3, 1'b1, 15'd490, 15'h5678, 1'b0);
    sp_behind_bg = 1'b1;
    dot("cgb_behind", 1'b1, 8'd10, 8'd3, 1'b1, 15'd490, 15'h1234, 1'b0);

    // DMG sprite-behind-BG cases
    cgb = 1'b0; sp_color = 2'd2; sp_dmg_pal = 1'b1; bg_pixel = 6'b000000;
    dot("dmg_obp1", 1'b1, 8'd0, 8'd1, 1'b1, 15'd160, 15'h56B5, 1'b0);
    sp_dmg_pal = 1'b0;
    dot("dmg_obp0", 1'b1, 8'd0, 8'd1, 1'b1, 15'd160, 15'h294A, 1'b0);
    bg_pixel = 6'b000011;
    dot("dmg_behind", 1'b1, 8'd0, 8'd1, 1'b1, 15'd160, 15'h0000, 1'b0);
    sp_behind_bg = 1'b0;
    dot("dmg_front", 1'b1, 8'd0, 8'd1, 1'b1, 15'd160, 15'h294A, 1'b0);

    // OCPS auto-increment wrap from 63 to 0
    reg_write(2'd2, 8'hBF);
    reg_write(2'd3, 8'hAA);
    reg_write(2'd3, 8'h55);
    reg_check("wrap.ocps", 2'd2, 8'hC1);
    reg_write(2'd2, 8'h3F);
    reg_check("wrap.byte63", 2'd3, 8'hAA);
    reg_check("wrap.ocps63", 2'd2, 8'h7F);
    reg_write(2'd2, 8'h00);
    reg_check("wrap.byte0", 2'd3, 8'h55);
    reg_check("wrap.ocps0", 2'd2, 8'h40);

    // Off-screen and non-rendering dots
    dot("x_oob", 1'b1, 8'hF0, 8'd0, 1'b0, 15'd0, 15'd0, 1'b0);
    dot("no_render", 1'b0, 8'd7, 8'd0, 1'b0, 15'd0, 15'd0, 1'b0);

    // Reset between accept and write
    @(negedge clk); slow_clk_en = 1'b1; rendering = 1'b1; pixel_x = 8'd20; ly = 8'd0;
    @(negedge clk); slow_clk_en = 1'b0; rendering = 1'b0;
    @(negedge clk); slow_clk_en = 1'b1;
    @(negedge clk); slow_clk_en = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0; slow_clk_en = 1'b1;
    @(negedge clk); slow_clk_en = 1'b0;
    check("rst_mid.fb_we", fb_we, 0);
    check("rst_mid.fb_addr", fb_addr, 0);
    check("rst_mid.fb_wdata", fb_wdata, 0);
    check("rst_mid.frame_done", frame_done, 0);
    @(negedge clk); slow_clk_en = 1'b1;
    @(negedge clk); slow_clk_en = 1'b0;
    check("rst_mid.fb_we_late", fb_we, 0);
    reg_check("rst_mid.bcps", 2'd0, 8'h40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_writer.md
Name: lcd_pixel_writer

Overview:
- Consumes the per-dot pixel stream from the background renderer and the sprite pipeline.
- Resolves BG/sprite priority and maps the winning pixel to RGB555, through the DMG palette registers or the CGB palette RAM.
- Writes one frame-buffer word per visible dot.
- Also owns the CPU-visible BCPS/BCPD/OCPS/OCPD registers.

Parameters:
- FB_WIDTH, 160, visible pixels per line.
- FB_LINES, 144, visible lines per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- slow_clk_en  in  1  dot-rate enable; all pipeline state advances only when high
- cgb  in  1  CGB mode
- rendering  in  1  pixel_x/bg_pixel are valid this dot
- pixel_x  in  8  current dot column; valid 0..159 while rendering
- ly  in  8  current line
- bg_pixel  in  6  {prio, pal[2:0], color[1:0]}
- bg_master  in  1  LCDC.0 in CGB mode (0 = sprites always win)
- sp_color  in  2  sprite colour index; 0 = transparent
- sp_palette  in  3  CGB OBJ palette number
- sp_dmg_pal  in  1  DMG palette select: 0 = OBP0, 1 = OBP1
- sp_behind_bg  in  1  OAM attribute bit 7
- bgp, obp0, obp1  in  8 each  DMG palette registers
- reg_wr  in  1  CPU register write strobe, one clk
- reg_sel  in  2  0 = BCPS, 1 = BCPD, 2 = OCPS, 3 = OCPD
- reg_wdata  in  8  CPU write data
- reg_rdata  out  8  CPU read data for reg_sel, combinational
- fb_we  out  1  frame-buffer write strobe
- fb_addr  out  15  ly*160 + x
- fb_wdata  out  15  RGB555 {b, g, r}
- frame_done  out  1  one-clk pulse after pixel (159,143) is written

Behaviour:
- Reset values:
  - fb_we, frame_done, fb_addr, fb_wdata = 0.
  - BCPS and OCPS index/auto-increment = 0.
  - Both palette RAMs (64 bytes each) = 0xFF.
  - Pipeline valid bits = 0.
- Reset mid-line discards in-flight pixels; no write issues.
- Accept a dot when slow_clk_en & rendering & pixel_x < 160. Otherwise stage 0 valid = 0.
- Stage 0 (mix), registered on the accept edge:
  - bc = bg_pixel[1:0].
  - If sp_color == 0 → BG wins.
  - CGB: if ~bg_master → sprite wins; else if bc != 0 & (bg_pixel[5] | sp_behind_bg) → BG wins; else sprite wins.
  - DMG: if sp_behind_bg & bc != 0 → BG wins; else sprite wins.
  - Latch {src, palette, color, x, ly}.
- Stage 1 (lookup), next slow_clk_en:
  - CGB: byte address = 8*pal + 2*color. Low byte = bits 7:0, next byte = bits 14:8; bit 7 of the high byte is ignored.
  - DMG: shade = selected register bits [2c+1:2c]. Shade 0 → 7FFF, 1 → 56B5, 2 → 294A, 3 → 0000.
  - fb_addr = ly*160 + x, computed as (ly<<7) + (ly<<5) + x.
- Stage 2: fb_we pulses for exactly one clk, on the slow_clk_en clk two enables after accept, with registered fb_addr/fb_wdata.
- Latency: 2 slow_clk_en ticks, accept to write.
- frame_done pulses on the same clk as the fb_we for ly = 143, x = 159.
- pixel_x outside 0..159 (e.g. negative renderer counts 0xE9..0xFF) or rendering = 0 produces no write, even though the pipeline keeps draining.
- Registers:
  - BCPS/OCPS write: index = wdata[5:0], inc = wdata[7].
  - BCPS/OCPS read: {inc, 1'b1, index}.
  - BCPD/OCPD write stores the byte at index; if inc, index ← index + 1 mod 64 (63 wraps to 0).
  - BCPD/OCPD read returns the byte at index and never increments.
  - Register writes are accepted regardless of slow_clk_en or mode; access blocking is upstream.
- Palette RAM has an independent pixel read port. A CPU write and a pixel lookup to the same byte in the same clk: lookup returns the old value.
- In DMG mode the palette RAMs are untouched by lookup but remain CPU-writable.

Decomposition:
- Shared ppu package:
  - reg_sel enum.
  - DMG shade RGB555 constants.
  - FB size constants.
  - mixed-pixel struct {src, pal, color, x, ly}.
- One sub-module: cgb_palette_ram, instantiated twice for BG and OBJ. It holds 64x8 storage, the index/inc register, a CPU port and the pixel read port returning 15 bits.

Test Plan:
- DMG, bgp = 0xE4, bg color 2, sp_color 0, x = 5, ly = 0 → two enables later fb_we, addr 5, data 294A.
- CGB: write BCPS = 0x88, then BCPD 0x1F, 0x00 (palette 1 colour 0 = red); BCPS read = 0xCA. bg_pixel = {0,001,00} at x = 159, ly = 143 → fb_addr 23039, data 001F, frame_done pulses once.
- CGB priority, bg_master = 1, bg color 1, prio = 1, sp_color 3 → BG colour written. Same stimulus with bg_master = 0 → sprite colour written.
- DMG sp_behind_bg = 1: bg color 0 → sprite written (obp1 shade when sp_dmg_pal = 1). bg color 3 → BG written.
- OCPS = 0xBF, OCPD write 0xAA, 0x55 → bytes 63 and 0 written, index wraps to 1.
- pixel_x 0xF0 with rendering high, and any dot with rendering low → no fb_we. Assert reset between accept and write → no fb_we, all outputs 0.
